// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALUOp classes and the ID/EX control bundle.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } idex_ctrl_t;

  localparam idex_ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two read ports, one write port, $0 hardwired to zero,
// and a same-cycle bypass so ID sees the value WB is writing this cycle.
module regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = mem_q[raddr1_i];
    rdata2_o = mem_q[raddr2_i];
    if (we_i && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
    if (we_i && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
    // $0 check last so a bypassed write to $0 can never leak through
    if (raddr1_i == 5'd0) rdata1_o = '0;
    if (raddr2_i == 5'd0) rdata2_o = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decode, register read, beq/j resolution,
// load-use and branch-operand hazard stalls, and the ID/EX register.
module id_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] PC_if,
  input  logic        IF_flush,
  input  logic        RegWrite_wb,
  input  logic [4:0]  WriteReg_wb,
  input  logic [31:0] WriteData_wb,
  input  logic        MemRead_ex,
  input  logic        RegWrite_ex,
  input  logic [4:0]  WriteReg_ex,
  input  logic        RegWrite_mem,
  input  logic [4:0]  WriteReg_mem,
  output logic        IFWrite,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] JumpAddr,
  output logic [31:0] PC4_ex,
  output logic [31:0] ReadData1_ex,
  output logic [31:0] ReadData2_ex,
  output logic [31:0] Imm_ex,
  output logic [4:0]  Rs_ex,
  output logic [4:0]  Rt_ex,
  output logic [4:0]  Rd_ex,
  output logic        RegWrite_idex,
  output logic        MemRead_idex,
  output logic        MemWrite_idex,
  output logic        MemtoReg_idex,
  output logic        ALUSrc_idex,
  output logic        RegDst_idex,
  output logic [1:0]  ALUOp_idex
);

  logic [31:0] instr_id_q, pc_id_q;
  logic        valid_id_q;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, pc4, rdata1, rdata2;
  logic        is_beq, is_j, load_use, branch_haz, stall;
  idex_ctrl_t  ctrl_dec, ctrl_d, ctrl_q;
  logic [31:0] pc4_ex_q, rd1_ex_q, rd2_ex_q, imm_ex_q;
  logic [4:0]  rs_ex_q, rt_ex_q, rd_ex_q;

  assign opcode  = instr_id_q[31:26];
  assign rs      = instr_id_q[25:21];
  assign rt      = instr_id_q[20:16];
  assign rd      = instr_id_q[15:11];
  assign imm_ext = {{16{instr_id_q[15]}}, instr_id_q[15:0]};
  assign pc4     = pc_id_q + 32'd4;

  always_comb begin
    ctrl_dec = CTRL_NOP;
    is_beq   = 1'b0;
    is_j     = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_dst   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
        ctrl_dec.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_dec.alu_src    = 1'b1;
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.mem_write = 1'b1;
      end
      OP_ADDI: begin
        ctrl_dec.alu_src   = 1'b1;
        ctrl_dec.reg_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl_dec.alu_op = ALUOP_SUB;
        is_beq          = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  regfile u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (RegWrite_wb),
    .waddr_i  (WriteReg_wb),
    .wdata_i  (WriteData_wb),
    .raddr1_i (rs),
    .raddr2_i (rt),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  // j carries a target in the rs/rt field positions, so it is kept out of hazard checks
  assign load_use = valid_id_q && !is_j && MemRead_ex && (WriteReg_ex != 5'd0) &&
                    ((WriteReg_ex == rs) || (WriteReg_ex == rt));
  assign branch_haz = valid_id_q && is_beq &&
                      ((RegWrite_ex && (WriteReg_ex != 5'd0) &&
                        ((WriteReg_ex == rs) || (WriteReg_ex == rt))) ||
                       (RegWrite_mem && (WriteReg_mem != 5'd0) &&
                        ((WriteReg_mem == rs) || (WriteReg_mem == rt))));
  assign stall    = load_use || branch_haz;

  assign IFWrite  = !stall;
  assign Branch   = valid_id_q && is_beq && !stall && (rdata1 == rdata2);
  assign Jump     = valid_id_q && is_j;
  assign JumpAddr = is_j ? {pc4[31:28], instr_id_q[25:0], 2'b00}
                         : pc4 + {imm_ext[29:0], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_id_q <= '0;
      pc_id_q    <= RESET_PC;
      valid_id_q <= 1'b0;
    end else if (IF_flush || Branch || Jump) begin
      instr_id_q <= '0;
      valid_id_q <= 1'b0;
    end else if (IFWrite) begin
      instr_id_q <= Instruction_if;
      pc_id_q    <= PC_if;
      valid_id_q <= 1'b1;
    end
  end

  assign ctrl_d = (valid_id_q && !stall) ? ctrl_dec : CTRL_NOP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= CTRL_NOP;
      pc4_ex_q <= RESET_PC;
      rd1_ex_q <= '0;
      rd2_ex_q <= '0;
      imm_ex_q <= '0;
      rs_ex_q  <= '0;
      rt_ex_q  <= '0;
      rd_ex_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc4_ex_q <= pc4;
      rd1_ex_q <= rdata1;
      rd2_ex_q <= rdata2;
      imm_ex_q <= imm_ext;
      rs_ex_q  <= rs;
      rt_ex_q  <= rt;
      rd_ex_q  <= rd;
    end
  end

  assign PC4_ex        = pc4_ex_q;
  assign ReadData1_ex  = rd1_ex_q;
  assign ReadData2_ex  = rd2_ex_q;
  assign Imm_ex        = imm_ex_q;
  assign Rs_ex         = rs_ex_q;
  assign Rt_ex         = rt_ex_q;
  assign Rd_ex         = rd_ex_q;
  assign RegWrite_idex = ctrl_q.reg_write;
  assign MemRead_idex  = ctrl_q.mem_read;
  assign MemWrite_idex = ctrl_q.mem_write;
  assign MemtoReg_idex = ctrl_q.mem_to_reg;
  assign ALUSrc_idex   = ctrl_q.alu_src;
  assign RegDst_idex   = ctrl_q.reg_dst;
  assign ALUOp_idex    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// hazard, branch, jump, bypass and reset sequences.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instruction_if, PC_if;
  logic        IF_flush;
  logic        RegWrite_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] WriteData_wb;
  logic        MemRead_ex, RegWrite_ex, RegWrite_mem;
  logic [4:0]  WriteReg_ex, WriteReg_mem;
  logic        IFWrite, Branch, Jump;
  logic [31:0] JumpAddr, PC4_ex, ReadData1_ex, ReadData2_ex, Imm_ex;
  logic [4:0]  Rs_ex, Rt_ex, Rd_ex;
  logic        RegWrite_idex, MemRead_idex, MemWrite_idex, MemtoReg_idex;
  logic        ALUSrc_idex, RegDst_idex;
  logic [1:0]  ALUOp_idex;
  logic [7:0]  ctrl_ex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC_if(PC_if),
    .IF_flush(IF_flush), .RegWrite_wb(RegWrite_wb), .WriteReg_wb(WriteReg_wb),
    .WriteData_wb(WriteData_wb), .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex),
    .WriteReg_ex(WriteReg_ex), .RegWrite_mem(RegWrite_mem), .WriteReg_mem(WriteReg_mem),
    .IFWrite(IFWrite), .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr),
    .PC4_ex(PC4_ex), .ReadData1_ex(ReadData1_ex), .ReadData2_ex(ReadData2_ex),
    .Imm_ex(Imm_ex), .Rs_ex(Rs_ex), .Rt_ex(Rt_ex), .Rd_ex(Rd_ex),
    .RegWrite_idex(RegWrite_idex), .MemRead_idex(MemRead_idex),
    .MemWrite_idex(MemWrite_idex), .MemtoReg_idex(MemtoReg_idex),
    .ALUSrc_idex(ALUSrc_idex), .RegDst_idex(RegDst_idex), .ALUOp_idex(ALUOp_idex)
  );

  // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp}
  assign ctrl_ex = {RegWrite_idex, MemRead_idex, MemWrite_idex, MemtoReg_idex,
                    ALUSrc_idex, RegDst_idex, ALUOp_idex};

  localparam logic [7:0] C_R    = 8'b1000_0110;
  localparam logic [7:0] C_LW   = 8'b1101_1000;
  localparam logic [7:0] C_SW   = 8'b0010_1000;
  localparam logic [7:0] C_ADDI = 8'b1000_1000;
  localparam logic [7:0] C_BEQ  = 8'b0000_0001;
  localparam logic [7:0] C_NONE = 8'b0000_0000;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic [4:0]  rs, rt, rd;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Instruction_if = 32'h0;
    IF_flush       = 1'b0;
    RegWrite_wb    = 1'b0;
    WriteReg_wb    = 5'd0;
    WriteData_wb   = 32'h0;
    MemRead_ex     = 1'b0;
    RegWrite_ex    = 1'b0;
    WriteReg_ex    = 5'd0;
    RegWrite_mem   = 1'b0;
    WriteReg_mem   = 5'd0;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    RegWrite_wb  = 1'b1;
    WriteReg_wb  = r;
    WriteData_wb = d;
    tick();
    RegWrite_wb  = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"add",   enc_r(5'd1, 5'd2, 5'd3, 6'h20),         C_R,    32'h0000_1820, 5'd1, 5'd2, 5'd3};
    vecs[1] = '{"lw",    enc_i(6'h23, 5'd0, 5'd2, 16'h0004),     C_LW,   32'h0000_0004, 5'd0, 5'd2, 5'd0};
    vecs[2] = '{"sw",    enc_i(6'h2B, 5'd4, 5'd5, 16'hFFF8),     C_SW,   32'hFFFF_FFF8, 5'd4, 5'd5, 5'd31};
    vecs[3] = '{"addi",  enc_i(6'h08, 5'd6, 5'd7, 16'h7FFF),     C_ADDI, 32'h0000_7FFF, 5'd6, 5'd7, 5'd15};
    vecs[4] = '{"beq",   enc_i(6'h04, 5'd0, 5'd0, 16'h8000),     C_BEQ,  32'hFFFF_8000, 5'd0, 5'd0, 5'd16};
    vecs[5] = '{"j",     enc_j(26'h40),                          C_NONE, 32'h0000_0040, 5'd0, 5'd0, 5'd0};
    vecs[6] = '{"undef", enc_i(6'h3F, 5'd1, 5'd2, 16'h1234),     C_NONE, 32'h0000_1234, 5'd1, 5'd2, 5'd2};

    idle();
    PC_if = 32'h0000_0200;
    Instruction_if = enc_i(6'h23, 5'd0, 5'd2, 16'h0004);
    reset = 1'b0;
    tick();
    tick();
    chk("rst_ifwrite", {31'd0, IFWrite}, 32'd1);
    chk("rst_ctrl", {24'd0, ctrl_ex}, {24'd0, C_NONE});
    chk("rst_branch", {31'd0, Branch}, 32'd0);
    chk("rst_jump", {31'd0, Jump}, 32'd0);
    chk("rst_pc4_ex", PC4_ex, 32'h0000_0100);

    reset = 1'b1;
    tick();
    chk("rst_rel_edge1_ctrl", {24'd0, ctrl_ex}, {24'd0, C_NONE});
    Instruction_if = 32'h0;
    tick();
    chk("rst_rel_lw_ctrl", {24'd0, ctrl_ex}, {24'd0, C_LW});
    chk("rst_rel_lw_rt", {27'd0, Rt_ex}, 32'd2);
    chk("rst_rel_lw_pc4", PC4_ex, 32'h0000_0204);

    wb_write(5'd1, 32'h0000_0011);
    wb_write(5'd4, 32'h0000_0044);
    wb_write(5'd7, 32'h0000_0077);

    for (int i = 0; i < 7; i++) begin
      Instruction_if = vecs[i].instr;
      PC_if = 32'h0000_0400 + 32'(i * 4);
      tick();
      Instruction_if = 32'h0;
      tick();
      chk({vecs[i].name, "_ctrl"}, {24'd0, ctrl_ex}, {24'd0, vecs[i].ctrl});
      chk({vecs[i].name, "_imm"}, Imm_ex, vecs[i].imm);
      chk({vecs[i].name, "_rs"}, {27'd0, Rs_ex}, {27'd0, vecs[i].rs});
      chk({vecs[i].name, "_rt"}, {27'd0, Rt_ex}, {27'd0, vecs[i].rt});
      chk({vecs[i].name, "_rd"}, {27'd0, Rd_ex}, {27'd0, vecs[i].rd});
      chk({vecs[i].name, "_pc4"}, PC4_ex, 32'h0000_0404 + 32'(i * 4));
    end
    tick();

    // load-use: lw $2 in EX, add $3,$2,$4 in ID
    Instruction_if = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
    PC_if = 32'h0000_0300;
    tick();
    Instruction_if = enc_i(6'h08, 5'd0, 5'd9, 16'h0001);
    PC_if = 32'h0000_0304;
    MemRead_ex = 1'b1; RegWrite_ex = 1'b1; WriteReg_ex = 5'd2;
    #1;
    chk("lu_ifwrite_stall", {31'd0, IFWrite}, 32'd0);
    tick();
    MemRead_ex = 1'b0; RegWrite_ex = 1'b0; WriteReg_ex = 5'd0;
    RegWrite_mem = 1'b1; WriteReg_mem = 5'd2;
    #1;
    chk("lu_bubble", {24'd0, ctrl_ex}, {24'd0, C_NONE});
    chk("lu_ifwrite_resume", {31'd0, IFWrite}, 32'd1);
    tick();
    RegWrite_mem = 1'b0; WriteReg_mem = 5'd0;
    Instruction_if = 32'h0;
    chk("lu_add_ctrl", {24'd0, ctrl_ex}, {24'd0, C_R});
    chk("lu_add_rs", {27'd0, Rs_ex}, 32'd2);
    chk("lu_add_rd1", ReadData1_ex, 32'h0);
    chk("lu_add_rd2", ReadData2_ex, 32'h0000_0044);
    tick();
    chk("lu_next_addi", {24'd0, ctrl_ex}, {24'd0, C_ADDI});
    chk("lu_next_rt", {27'd0, Rt_ex}, 32'd9);

    // beq $1,$1,+3 at 0x10: taken to 0x20
    Instruction_if = enc_i(6'h04, 5'd1, 5'd1, 16'h0003);
    PC_if = 32'h0000_0010;
    tick();
    Instruction_if = enc_i(6'h08, 5'd0, 5'd9, 16'h0005);
    PC_if = 32'h0000_0014;
    #1;
    chk("beq_taken", {31'd0, Branch}, 32'd1);
    chk("beq_target", JumpAddr, 32'h0000_0020);
    chk("beq_jump_low", {31'd0, Jump}, 32'd0);
    tick();
    Instruction_if = 32'h0;
    chk("beq_flush_branch", {31'd0, Branch}, 32'd0);
    chk("beq_idex_beq", {24'd0, ctrl_ex}, {24'd0, C_BEQ});
    tick();
    chk("beq_flush_bubble", {24'd0, ctrl_ex}, {24'd0, C_NONE});

    // beq $1,$4 not taken (0x11 vs 0x44)
    Instruction_if = enc_i(6'h04, 5'd1, 5'd4, 16'h0003);
    PC_if = 32'h0000_0030;
    tick();
    Instruction_if = 32'h0;
    #1;
    chk("beq_not_taken", {31'd0, Branch}, 32'd0);
    tick();

    // j 0x40 at 0x1000_0008
    Instruction_if = enc_j(26'h40);
    PC_if = 32'h1000_0008;
    tick();
    Instruction_if = 32'h0;
    #1;
    chk("j_jump", {31'd0, Jump}, 32'd1);
    chk("j_target", JumpAddr, 32'h1000_0100);
    chk("j_ifwrite", {31'd0, IFWrite}, 32'd1);
    tick();
    chk("j_flushed", {31'd0, Jump}, 32'd0);

    // WB bypass into ID, and writes to $0 ignored
    Instruction_if = enc_r(5'd5, 5'd0, 5'd3, 6'h20);
    tick();
    Instruction_if = enc_r(5'd0, 5'd0, 5'd3, 6'h20);
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd5; WriteData_wb = 32'hDEAD_BEEF;
    tick();
    chk("byp_rd1", ReadData1_ex, 32'hDEAD_BEEF);
    Instruction_if = enc_r(5'd0, 5'd5, 5'd3, 6'h20);
    WriteReg_wb = 5'd0; WriteData_wb = 32'hFFFF_FFFF;
    tick();
    RegWrite_wb = 1'b0;
    Instruction_if = 32'h0;
    chk("r0_bypass_rd1", ReadData1_ex, 32'h0);
    tick();
    chk("r0_after_rd1", ReadData1_ex, 32'h0);
    chk("r5_stored_rd2", ReadData2_ex, 32'hDEAD_BEEF);

    // beq $6,$7 with $6 producer: EX, then MEM, then WB bypass
    Instruction_if = enc_i(6'h04, 5'd6, 5'd7, 16'h0001);
    PC_if = 32'h0000_0200;
    tick();
    Instruction_if = 32'h0;
    RegWrite_ex = 1'b1; WriteReg_ex = 5'd6;
    #1;
    chk("bst_c1_ifwrite", {31'd0, IFWrite}, 32'd0);
    chk("bst_c1_branch", {31'd0, Branch}, 32'd0);
    tick();
    RegWrite_ex = 1'b0; WriteReg_ex = 5'd0;
    RegWrite_mem = 1'b1; WriteReg_mem = 5'd6;
    #1;
    chk("bst_c2_ifwrite", {31'd0, IFWrite}, 32'd0);
    chk("bst_c2_bubble", {24'd0, ctrl_ex}, {24'd0, C_NONE});
    tick();
    RegWrite_mem = 1'b0; WriteReg_mem = 5'd0;
    RegWrite_wb = 1'b1; WriteReg_wb = 5'd6; WriteData_wb = 32'h0000_0077;
    #1;
    chk("bst_c3_ifwrite", {31'd0, IFWrite}, 32'd1);
    chk("bst_c3_branch", {31'd0, Branch}, 32'd1);
    chk("bst_c3_target", JumpAddr, 32'h0000_0208);
    tick();
    RegWrite_wb = 1'b0;
    chk("bst_idex_ctrl", {24'd0, ctrl_ex}, {24'd0, C_BEQ});
    chk("bst_idex_rd1", ReadData1_ex, 32'h0000_0077);

    // IF_flush during a branch stall: bubble, no branch
    Instruction_if = enc_i(6'h04, 5'd6, 5'd7, 16'h0001);
    PC_if = 32'h0000_0240;
    tick();
    Instruction_if = 32'h0;
    RegWrite_ex = 1'b1; WriteReg_ex = 5'd7;
    IF_flush = 1'b1;
    #1;
    chk("fst_ifwrite", {31'd0, IFWrite}, 32'd0);
    tick();
    idle();
    #1;
    chk("fst_branch", {31'd0, Branch}, 32'd0);
    chk("fst_ifwrite_after", {31'd0, IFWrite}, 32'd1);
    chk("fst_idex_bubble1", {24'd0, ctrl_ex}, {24'd0, C_NONE});
    tick();
    chk("fst_idex_bubble2", {24'd0, ctrl_ex}, {24'd0, C_NONE});

    // reset during a load-use stall
    Instruction_if = enc_r(5'd2, 5'd4, 5'd3, 6'h20);
    tick();
    Instruction_if = 32'h0;
    MemRead_ex = 1'b1; RegWrite_ex = 1'b1; WriteReg_ex = 5'd2;
    #1;
    chk("mrst_stall", {31'd0, IFWrite}, 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst_ifwrite", {31'd0, IFWrite}, 32'd1);
    chk("mrst_pc4", PC4_ex, 32'h0000_0100);
    idle();
    tick();
    reset = 1'b1;
    Instruction_if = enc_r(5'd1, 5'd7, 5'd3, 6'h20);
    tick();
    Instruction_if = 32'h0;
    tick();
    chk("mrst_rf_clear1", ReadData1_ex, 32'h0);
    chk("mrst_rf_clear2", ReadData2_ex, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
